// File: rtl/mul_div_unit.sv
// Iterative 64x64 multiply / unsigned divide unit, one radix-2 step per clock (64 steps per operation).
// Optional divider datapath is compiled in only when MULDIV_DIV_EN is defined.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] readData1,
    input  logic [63:0] readData2,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [63:0] writeData,
    output logic [4:0]  writeReg,
    output logic        RegWrite,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [1:0]   r_op;
    logic [63:0]  r_b;
    logic [127:0] r_acc;
    logic [6:0]   r_cnt;

    // Multiply: r_acc = {partial_high, multiplier}; add B on the low bit, then shift right.
    logic [64:0]  w_mul_sum;
    logic [127:0] w_mul_next;
    logic [127:0] w_step;
    logic [63:0]  w_result;
    logic         w_unsup;

    assign w_mul_sum  = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_b} : 65'd0);
    assign w_mul_next = {w_mul_sum, r_acc[63:1]};

`ifdef MULDIV_DIV_EN
    // Restoring divide: r_acc = {remainder, quotient/dividend}; B=0 naturally yields all-ones / A.
    logic [64:0]  w_div_trial;
    logic [127:0] w_div_next;

    assign w_div_trial = {r_acc[127:64], r_acc[63]} - {1'b0, r_b};
    assign w_div_next  = w_div_trial[64] ? {r_acc[126:0], 1'b0}
                                         : {w_div_trial[63:0], r_acc[62:0], 1'b1};
    assign w_step      = r_op[1] ? w_div_next : w_mul_next;
    assign w_unsup     = 1'b0;
`else
    assign w_step      = w_mul_next;
    assign w_unsup     = r_op[1];
`endif

    // MULHU and REMU both live in the upper half of the accumulator.
    assign w_result = r_op[0] ? w_step[127:64] : w_step[63:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 2'd0;
            r_b       <= 64'd0;
            r_acc     <= 128'd0;
            r_cnt     <= 7'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            writeData <= 64'd0;
            writeReg  <= 5'd0;
            RegWrite  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_op     <= op;
                        r_b      <= readData2;
                        r_acc    <= {64'd0, readData1};
                        r_cnt    <= 7'd0;
                        writeReg <= rd;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 7'd1;
                    if (w_unsup || r_cnt == 7'd63) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        writeData <= w_unsup ? 64'd0 : w_result;
                        err       <= w_unsup;
                        RegWrite  <= !w_unsup && (writeReg != 5'd0);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    RegWrite <= 1'b0;
                    err      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divider vectors are enabled with MULDIV_DIV_EN.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [63:0] readData1;
    logic [63:0] readData2;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [63:0] writeData;
    logic [4:0]  writeReg;
    logic        RegWrite;
    logic        err;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .readData1 (readData1),
        .readData2 (readData2),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .writeData (writeData),
        .writeReg  (writeReg),
        .RegWrite  (RegWrite),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble operands after accept, wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] r, output int lat, output logic busy_acc,
                          output logic [63:0] wd, output logic [4:0] wr, output logic rw,
                          output logic e, output logic done_after, output logic busy_after);
        @(negedge clk);
        op = o; readData1 = a; readData2 = b; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        readData1 = {$urandom, $urandom}; readData2 = {$urandom, $urandom}; rd = 5'($urandom);
        busy_acc = busy;
        lat = -1; wd = 'x; wr = 'x; rw = 1'bx; e = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n; wd = writeData; wr = writeReg; rw = RegWrite; e = err;
                break;
            end
        end
        @(posedge clk); #1;
        done_after = done; busy_after = busy;
        $display("op=%0d a=%h b=%h rd=%0d -> lat=%0d writeData=%h writeReg=%0d RegWrite=%0b err=%0b",
                 o, a, b, r, lat, wd, wr, rw, e);
    endtask

    int          lat;
    logic        busy_acc, rw, e, done_after, busy_after;
    logic [63:0] wd;
    logic [4:0]  wr;
    int          n_done;
    int          first_done;
    logic        rw_at_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; readData1 = 64'd0; readData2 = 64'd0; rd = 5'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_err", err, 0);
        chk("rst_writedata", writeData, 0);
        chk("rst_writereg", writeReg, 0);
        #20;
        @(negedge clk); reset = 1'b0;

        // MUL 7*6
        run_op(2'b00, 64'd7, 64'd6, 5'd5, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("mul_busy_accept", busy_acc, 1);
        chk("mul_latency", lat, 64);
        chk("mul_data", wd, 64'd42);
        chk("mul_writereg", wr, 5'd5);
        chk("mul_regwrite", rw, 1);
        chk("mul_err", e, 0);
        chk("mul_done_one_cycle", done_after, 0);
        chk("mul_busy_released", busy_after, 0);

        // MULHU and MUL of 2^63 * 4
        run_op(2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd9, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("mulhu_latency", lat, 64);
        chk("mulhu_data", wd, 64'd2);
        run_op(2'b00, 64'h8000_0000_0000_0000, 64'd4, 5'd9, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("mul_low_data", wd, 64'd0);

        // Full-width product: (2^64-1)^2 = 2^128 - 2^65 + 1
        run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("mulhu_max", wd, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("mul_max", wd, 64'd1);

`ifdef MULDIV_DIV_EN
        run_op(2'b10, 64'd100, 64'd7, 5'd1, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("divu_latency", lat, 64);
        chk("divu_data", wd, 64'd14);
        chk("divu_err", e, 0);
        chk("divu_regwrite", rw, 1);
        run_op(2'b11, 64'd100, 64'd7, 5'd2, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("remu_latency", lat, 64);
        chk("remu_data", wd, 64'd2);
        chk("remu_err", e, 0);
        run_op(2'b10, 64'd5, 64'd0, 5'd3, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("divu0_latency", lat, 64);
        chk("divu0_data", wd, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b11, 64'd5, 64'd0, 5'd4, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("remu0_latency", lat, 64);
        chk("remu0_data", wd, 64'd5);
`else
        run_op(2'b10, 64'd100, 64'd7, 5'd1, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("nodiv_latency", lat, 1);
        chk("nodiv_err", e, 1);
        chk("nodiv_data", wd, 64'd0);
        chk("nodiv_regwrite", rw, 0);
        chk("nodiv_done_one_cycle", done_after, 0);
        // MUL still works after an unsupported op
        run_op(2'b00, 64'd11, 64'd13, 5'd7, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("after_nodiv_mul", wd, 64'd143);
        chk("after_nodiv_err", e, 0);
`endif

        // MUL with rd=0, plus a start pulse at k+10 that must be ignored
        @(negedge clk);
        op = 2'b00; readData1 = 64'd12; readData2 = 64'd10; rd = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first_done = -1; rw_at_done = 1'b0; wd = 'x;
        for (int n = 1; n <= 150; n++) begin
            if (n == 10) begin
                op = 2'b01; readData1 = 64'd99; readData2 = 64'd99; rd = 5'd8; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = n; rw_at_done = RegWrite; wd = writeData;
                end
            end
        end
        $display("op=0 a=12 b=10 rd=0 (start at k+10) -> first_done=%0d dones=%0d writeData=%h RegWrite=%0b",
                 first_done, n_done, wd, rw_at_done);
        chk("rd0_latency", first_done, 64);
        chk("rd0_regwrite", rw_at_done, 0);
        chk("rd0_data", wd, 64'd120);
        chk("rd0_single_done", n_done, 1);

        // Reset mid-operation, asserted between clock edges
        @(negedge clk);
        op = 2'b00; readData1 = 64'd5; readData2 = 64'd5; rd = 5'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_regwrite", RegWrite, 0);
        chk("rst_mid_writedata", writeData, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        n_done = 0;
        for (int n = 0; n < 70; n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        $display("reset at k+30 -> dones after release=%0d", n_done);
        chk("rst_mid_no_done", n_done, 0);
        run_op(2'b00, 64'd3, 64'd3, 5'd4, lat, busy_acc, wd, wr, rw, e, done_after, busy_after);
        chk("post_rst_latency", lat, 64);
        chk("post_rst_data", wd, 64'd9);
        chk("post_rst_regwrite", rw, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL provide ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL provide: op  input  2  00 MUL (low 64), 01 MULHU (high 64, unsigned), 10 DIVU, 11 REMU.
REQ-005 SHALL provide: readData1  input  64  operand A, driven from register-file read port 1.
REQ-006 SHALL provide: readData2  input  64  operand B, driven from register-file read port 2.
REQ-007 SHALL provide: rd  input  5  destination register index, captured at accept.
REQ-008 SHALL provide: busy  output  1  high in RUN and DONE.
REQ-009 SHALL provide: done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide: writeData  output  64  result, valid while done=1, held until next accept.
REQ-011 SHALL provide: writeReg  output  5  captured rd.
REQ-012 SHALL provide: RegWrite  output  1  register-file write enable.
REQ-013 SHALL provide: err  output  1  unsupported-op flag, valid with done.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 SHALL, in IDLE with start=1 at edge k, capture op, readData1, readData2, rd, clear 7-bit counter, enter RUN.
REQ-016 SHALL perform one radix-2 iteration per RUN cycle (shift-add multiply into 128-bit accumulator; restoring divide with 64-bit remainder).
REQ-017 SHALL enter DONE at edge k+64; done=1 for exactly that one cycle; return to IDLE at edge k+65.
REQ-018 SHALL ignore start in RUN and DONE; operands need not stay stable after accept.
REQ-019 SHALL make MUL return product[63:0] and MULHU return product[127:64].
REQ-020 SHALL make DIVU return floor(A/B) and REMU return A mod B, both unsigned.
REQ-021 SHALL, when B=0, make DIVU return 64'hFFFF_FFFF_FFFF_FFFF and REMU return A, with unchanged latency.
REQ-022 SHALL assert RegWrite=done AND (writeReg != 0); done still pulses when rd=0.
REQ-023 SHALL keep err=0 for all ops when the divider is compiled in.

Reset
REQ-024 SHALL, on reset high, immediately force IDLE, counter 0, busy=0, done=0, RegWrite=0, err=0, writeData=0, writeReg=0, independent of clk.
REQ-025 SHALL abort any in-flight operation on reset with no done pulse, then accept start on the first edge after reset deasserts.

Configuration
REQ-026 SHALL compile the divider datapath only when macro MULDIV_DIV_EN is defined.
REQ-027 SHALL, with MULDIV_DIV_EN defined, behave per REQ-020/021/023.
REQ-028 SHALL, without MULDIV_DIV_EN, send op 10/11 from IDLE directly to DONE at edge k+1, with writeData=0, err=1, RegWrite=0; MUL/MULHU are unchanged.

Verification
REQ-029 SHALL cover: MUL A=7, B=6, rd=5 -> done at edge k+64, writeData=42, writeReg=5, RegWrite=1, err=0.
REQ-030 SHALL cover: MULHU A=64'h8000_0000_0000_0000, B=4 -> writeData=2; MUL same operands -> writeData=0.
REQ-031 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> all-ones; REMU 5/0 -> 5; each completes at k+64.
REQ-032 SHALL cover: MUL with rd=0 -> done=1, RegWrite=0; start pulsed at k+10 -> ignored, exactly one done.
REQ-033 SHALL cover: reset asserted at k+30 between edges -> busy/done/RegWrite low at once, no done pulse; new MUL 3*3 after release -> 9.
REQ-034 SHALL cover, without MULDIV_DIV_EN: DIVU 100/7 -> done at k+1, err=1, writeData=0, RegWrite=0.
